div_dispatch: RTL

Request-side front end for the 32-bit iterative integer divider. Accepts tagged divide requests over a valid/ready handshake, buffers them in a small FIFO and issues them one at a time with a single-cycle `calc` pulse. It captures quotient/remainder on the divider's done strobe and returns them with the original tag over a valid/ready response port. Sits directly upstream of the divider and shields the divider's strobe-only interface from the rest of the datapath.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_req_fifo.sv | 47 ++++
 rtl/div_dispatch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider request dispatcher.
// Used by div_req_fifo and div_dispatch.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  // Width of the tag field carried through the request FIFO; div_dispatch
  // TAG_W values above this need the field widened here.
  localparam int unsigned DIV_TAG_W = 4;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } div_state_t;

  typedef struct packed {
    logic [DIV_W-1:0]     dividend;
    logic [DIV_W-1:0]     divisor;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO, power-of-two depth, async active-low reset.
// Head entry is presented combinationally while non-empty.
module div_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  // Read/write pointers with a wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)
        r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop && !o_empty)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (i_push && !o_full)
      r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/div_dispatch.sv
// Request-side front end for the 32-bit iterative divider: buffers tagged
// requests, issues them one at a time with a single-cycle calc pulse and
// returns quotient/remainder with the tag over a valid/ready port.
// Optional feature: define DIV_TIMEOUT_EN to bound the WAIT state by TIMEOUT
// cycles (error response, then re-flush of the divider).
module div_dispatch
  import div_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned DRAIN_CYCLES = 40,
  parameter int unsigned TIMEOUT      = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_dividend,
  input  logic [DIV_W-1:0] req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DIV_W-1:0] rsp_quotient,
  output logic [DIV_W-1:0] rsp_remainder,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             div_calc,
  output logic [DIV_W-1:0] div_dividend,
  output logic [DIV_W-1:0] div_divisor,
  input  logic [DIV_W-1:0] div_quotient,
  input  logic [DIV_W-1:0] div_remainder,
  input  logic             div_done_stb,
  output logic             busy
);

  // One counter serves the drain window and, when enabled, the WAIT timeout,
  // so it is sized for the longer of the two.
  localparam int unsigned CNT_MAX = (DRAIN_CYCLES > TIMEOUT) ? DRAIN_CYCLES : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div_calc;
  logic [DIV_W-1:0] r_div_dividend;
  logic [DIV_W-1:0] r_div_divisor;
  logic [TAG_W-1:0] r_tag;
  logic             r_rsp_valid;
  logic [DIV_W-1:0] r_rsp_q;
  logic [DIV_W-1:0] r_rsp_r;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_busy;
`ifdef DIV_TIMEOUT_EN
  logic             r_rsp_err;
`endif

  div_req_t w_req;
  div_req_t w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_pop;

  // Pack the incoming request into the FIFO entry layout
  always_comb begin
    w_req.dividend = req_dividend;
    w_req.divisor  = req_divisor;
    w_req.tag      = DIV_TAG_W'(req_tag);
  end

  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;

  div_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(div_req_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Issue/response sequencer with registered divider and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_FLUSH;
      r_cnt          <= '0;
      r_div_calc     <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_tag          <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_q        <= '0;
      r_rsp_r        <= '0;
      r_rsp_tag      <= '0;
      r_busy         <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      r_rsp_err      <= 1'b0;
`endif
    end else begin
      r_div_calc <= 1'b0;
      r_busy     <= (r_state != ST_IDLE) || !w_empty;
      case (r_state)
        ST_FLUSH: begin
          if (div_done_stb || (r_cnt == CNT_W'(DRAIN_CYCLES - 1))) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (!w_empty) begin
            r_div_dividend <= w_head.dividend;
            r_div_divisor  <= w_head.divisor;
            r_tag          <= TAG_W'(w_head.tag);
            r_div_calc     <= 1'b1;
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
`ifdef DIV_TIMEOUT_EN
          // r_cnt holds the number of cycles elapsed since ISSUE
          r_cnt   <= CNT_W'(1);
`endif
        end
        ST_WAIT: begin
          if (div_done_stb) begin
            r_rsp_q     <= div_quotient;
            r_rsp_r     <= div_remainder;
            r_rsp_tag   <= r_tag;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_HOLD;
`ifdef DIV_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_tag   <= r_tag;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
`endif
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            if (r_rsp_err) begin
              r_rsp_err <= 1'b0;
              r_cnt     <= '0;
              r_state   <= ST_FLUSH;
            end else begin
              r_state <= ST_IDLE;
            end
`else
            r_state <= ST_IDLE;
`endif
          end
        end
        default: r_state <= ST_FLUSH;
      endcase
    end
  end

  assign div_calc      = r_div_calc;
  assign div_dividend  = r_div_dividend;
  assign div_divisor   = r_div_divisor;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_quotient  = r_rsp_q;
  assign rsp_remainder = r_rsp_r;
  assign rsp_tag       = r_rsp_tag;
  assign busy          = r_busy;
`ifdef DIV_TIMEOUT_EN
  assign rsp_err       = r_rsp_err;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule
